// File: rtl/uart_rx_frame_pkg.sv
// Shared definitions for the UART receiver: state encoding common with the
// transmitter, default oversampling rate and a clog2 helper for counter widths.
package uart_rx_frame_pkg;

    localparam int NUM_TICKS_DEFAULT = 16;

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        START  = 5'b00010,
        DATA   = 5'b00100,
        PARITY = 5'b01000,
        STOP   = 5'b10000
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_frame_sync.sv
// Multi-flop synchronizer for the asynchronous serial line; resets to idle (1).
// Ports: clk, reset (async, active-high), rx_in (async line), rxs (synchronized line).
module rx_sync
    import uart_rx_frame_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic rx_in,
    output logic rxs
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver: 16x-oversampled start/data/parity/stop recovery with
// a one-clk done strobe plus parity and framing error flags.
// Ports: clk, reset (async, active-high), tick (oversample pulse), rx_in (serial
// line), parity (even-parity enable), stop_bits (0 treated as 1), d_out, rx_done,
// parity_err, frame_err.
module uart_rx_frame
    import uart_rx_frame_pkg::*;
#(
    parameter int NUM_TICKS     = NUM_TICKS_DEFAULT,
    parameter int BITS_PER_DATA = 8,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tick,
    input  logic                     rx_in,
    input  logic                     parity,
    input  logic [1:0]               stop_bits,
    output logic [BITS_PER_DATA-1:0] d_out,
    output logic                     rx_done,
    output logic                     parity_err,
    output logic                     frame_err
);

    localparam int SW = clog2(NUM_TICKS);
    localparam int NW = (clog2(BITS_PER_DATA) > 0) ? clog2(BITS_PER_DATA) : 1;

    localparam logic [SW-1:0] S_MID  = SW'(NUM_TICKS / 2 - 1);
    localparam logic [SW-1:0] S_END  = SW'(NUM_TICKS - 1);
    localparam logic [NW-1:0] N_LAST = NW'(BITS_PER_DATA - 1);

    logic rxs;

    state_e                   state_q, state_d;
    logic [SW-1:0]            s_q, s_d;
    logic [NW-1:0]            n_q, n_d;
    logic [1:0]               k_q, k_d;
    logic [BITS_PER_DATA-1:0] sh_q, sh_d;
    logic                     par_q, par_d;
    logic [1:0]               stop_q, stop_d;
    logic                     perr_q, perr_d;
    logic                     ferr_q, ferr_d;
    logic                     armed_q, armed_d;
    logic [BITS_PER_DATA-1:0] dout_q, dout_d;
    logic                     pe_q, pe_d;
    logic                     fe_q, fe_d;
    logic                     done_q, done_d;

    rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .rx_in(rx_in),
        .rxs  (rxs)
    );

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        k_d     = k_q;
        sh_d    = sh_q;
        par_d   = par_q;
        stop_d  = stop_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        armed_d = armed_q;
        dout_d  = dout_q;
        pe_d    = pe_q;
        fe_d    = fe_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A held-low line (break) must return high before a new start arms.
                if (rxs) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == S_MID) begin
                        s_d = '0;
                        if (!rxs) begin
                            state_d = DATA;
                            n_d     = '0;
                            par_d   = parity;
                            stop_d  = (stop_bits == 2'd0) ? 2'd1 : stop_bits;
                            perr_d  = 1'b0;
                            ferr_d  = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == S_END) begin
                        s_d  = '0;
                        // LSB arrives first, so shifting in at the MSB rebuilds the word.
                        sh_d = {rxs, sh_q[BITS_PER_DATA-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = par_q ? PARITY : STOP;
                            k_d     = 2'd1;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    if (s_q == S_END) begin
                        s_d     = '0;
                        perr_d  = rxs ^ (^sh_q);
                        state_d = STOP;
                        k_d     = 2'd1;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_q == S_END) begin
                        s_d = '0;
                        if (!rxs) begin
                            ferr_d = 1'b1;
                        end
                        // Done fires mid-stop-bit so the next start edge is never missed.
                        if (k_q == stop_q) begin
                            dout_d  = sh_q;
                            pe_d    = perr_q & par_q;
                            fe_d    = ferr_q | ~rxs;
                            done_d  = 1'b1;
                            armed_d = 1'b0;
                            state_d = IDLE;
                        end else begin
                            k_d = k_q + 2'd1;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            k_q     <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            stop_q  <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            armed_q <= 1'b0;
            dout_q  <= '0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            k_q     <= k_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            stop_q  <= stop_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            armed_q <= armed_d;
            dout_q  <= dout_d;
            pe_q    <= pe_d;
            fe_q    <= fe_d;
            done_q  <= done_d;
        end
    end

    assign d_out      = dout_q;
    assign rx_done    = done_q;
    assign parity_err = pe_q;
    assign frame_err  = fe_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: a tick-driven line driver plays whole
// frames while a monitor collects done strobes for comparison with a frame model.
module tb_uart_rx_frame;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       rx_in = 1'b1;
    logic       parity = 1'b0;
    logic [1:0] stop_bits = 2'd1;
    logic [7:0] d_out;
    logic       rx_done;
    logic       parity_err;
    logic       frame_err;

    int vectors = 0;
    int miscompares = 0;
    bit jitter = 1'b0;

    logic [7:0] got_d[$];
    logic       got_pe[$];
    logic       got_fe[$];
    logic [7:0] exp_d[$];
    logic       exp_pe[$];
    logic       exp_fe[$];

    uart_rx_frame #(
        .NUM_TICKS    (16),
        .BITS_PER_DATA(8),
        .SYNC_STAGES  (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .rx_in     (rx_in),
        .parity    (parity),
        .stop_bits (stop_bits),
        .d_out     (d_out),
        .rx_done   (rx_done),
        .parity_err(parity_err),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            int g;
            g = jitter ? int'($urandom_range(5, 3)) : 4;
            repeat (g - 1) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rx_done === 1'b1) begin
                got_d.push_back(d_out);
                got_pe.push_back(parity_err);
                got_fe.push_back(frame_err);
            end
        end
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (tick !== 1'b1);
        end
        @(negedge clk);
    endtask

    task automatic drive_level(input logic b, input int n);
        rx_in = b;
        wait_ticks(n);
    endtask

    // Plays one frame as the transmitter would and records what the receiver must report.
    task automatic send_frame(input logic [7:0] data, input bit pen, input bit flip,
                              input int nstop, input logic [2:0] low_mask);
        int   eff;
        int   ones;
        bit   fe;
        logic pbit;
        eff  = (nstop == 0) ? 1 : nstop;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(data[i]);
        pbit = logic'(ones % 2) ^ flip;
        fe   = 1'b0;
        for (int k = 0; k < eff; k++) if (low_mask[k]) fe = 1'b1;
        exp_d.push_back(data);
        exp_pe.push_back(pen && flip);
        exp_fe.push_back(fe);
        parity    = pen;
        stop_bits = 2'(nstop);
        drive_level(1'b0, 16);
        parity    = 1'($urandom);
        stop_bits = 2'($urandom);
        for (int i = 0; i < 8; i++) drive_level(data[i], 16);
        if (pen) drive_level(pbit, 16);
        for (int k = 0; k < eff; k++) drive_level(!low_mask[k], 16);
        rx_in = 1'b1;
    endtask

    task automatic check_frames(input string name);
        int t;
        t = 0;
        while (got_d.size() < exp_d.size() && t < 5000) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (got_d.size() !== exp_d.size()) begin
            miscompares++;
            $display("FAIL %s count: got %0d frames, want %0d", name, got_d.size(), exp_d.size());
        end
        while (got_d.size() > 0 && exp_d.size() > 0) begin
            logic [7:0] gd, ed;
            logic       gp, ep, gf, ef;
            gd = got_d.pop_front();
            ed = exp_d.pop_front();
            gp = got_pe.pop_front();
            ep = exp_pe.pop_front();
            gf = got_fe.pop_front();
            ef = exp_fe.pop_front();
            vectors += 3;
            if (gd !== ed) begin
                miscompares++;
                $display("FAIL %s d_out: got %h want %h", name, gd, ed);
            end
            if (gp !== ep) begin
                miscompares++;
                $display("FAIL %s parity_err: got %b want %b", name, gp, ep);
            end
            if (gf !== ef) begin
                miscompares++;
                $display("FAIL %s frame_err: got %b want %b", name, gf, ef);
            end
        end
        got_d.delete();
        got_pe.delete();
        got_fe.delete();
        exp_d.delete();
        exp_pe.delete();
        exp_fe.delete();
    endtask

    task automatic check_quiet(input string name, input int n);
        wait_ticks(n);
        vectors++;
        if (got_d.size() != 0) begin
            miscompares++;
            $display("FAIL %s extra rx_done: got %0d pulses, want 0", name, got_d.size());
        end
        got_d.delete();
        got_pe.delete();
        got_fe.delete();
    endtask

    task automatic check_cleared(input string name);
        vectors += 4;
        if (d_out !== 8'h00) begin
            miscompares++;
            $display("FAIL %s d_out: got %h want 00", name, d_out);
        end
        if (rx_done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s rx_done: got %b want 0", name, rx_done);
        end
        if (parity_err !== 1'b0) begin
            miscompares++;
            $display("FAIL %s parity_err: got %b want 0", name, parity_err);
        end
        if (frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL %s frame_err: got %b want 0", name, frame_err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check_cleared("reset");
        reset = 1'b0;
        drive_level(1'b1, 32);
        check_quiet("reset_idle", 1);
    endtask

    task automatic test_basic();
        send_frame(8'hA5, 1'b0, 1'b0, 1, 3'b000);
        check_frames("basic_a5");
        check_quiet("basic_single", 48);
    endtask

    task automatic test_parity();
        send_frame(8'h3C, 1'b1, 1'b0, 1, 3'b000);
        check_frames("parity_ok");
        drive_level(1'b1, 16);
        send_frame(8'h3C, 1'b1, 1'b1, 1, 3'b000);
        check_frames("parity_bad");
        drive_level(1'b1, 16);
    endtask

    task automatic test_framing();
        send_frame(8'h55, 1'b0, 1'b0, 2, 3'b010);
        drive_level(1'b1, 16);
        check_frames("stop2_low");
        parity    = 1'b0;
        stop_bits = 2'd1;
        exp_d.push_back(8'h00);
        exp_pe.push_back(1'b0);
        exp_fe.push_back(1'b1);
        drive_level(1'b0, 20 * 16);
        check_frames("break");
        drive_level(1'b1, 32);
        check_quiet("break_release", 16);
    endtask

    task automatic test_glitch();
        drive_level(1'b0, 4);
        drive_level(1'b1, 48);
        check_quiet("glitch", 1);
        send_frame(8'h81, 1'b0, 1'b0, 1, 3'b000);
        check_frames("after_glitch");
        drive_level(1'b1, 16);
    endtask

    task automatic test_back_to_back();
        for (int pass = 0; pass < 2; pass++) begin
            jitter = (pass == 1);
            send_frame(8'h01, 1'b0, 1'b0, 1, 3'b000);
            send_frame(8'hFF, 1'b0, 1'b0, 1, 3'b000);
            send_frame(8'h80, 1'b0, 1'b0, 1, 3'b000);
            check_frames(pass == 1 ? "b2b_jitter" : "b2b");
            drive_level(1'b1, 16);
        end
        jitter = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] data;
        data = 8'hC3;
        parity    = 1'b0;
        stop_bits = 2'd1;
        drive_level(1'b0, 16);
        for (int i = 0; i < 3; i++) drive_level(data[i], 16);
        drive_level(data[3], 8);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_cleared("reset_mid");
        rx_in = 1'b1;
        reset = 1'b0;
        check_quiet("reset_mid_abort", 160);
        check_cleared("reset_mid_after");
        send_frame(8'h12, 1'b0, 1'b0, 1, 3'b000);
        check_frames("post_reset");
        drive_level(1'b1, 16);
    endtask

    task automatic test_random();
        for (int f = 0; f < 16; f++) begin
            logic [7:0] data;
            bit         pen, flip;
            int         nstop, eff;
            logic [2:0] mask;
            data  = 8'($urandom);
            pen   = 1'($urandom);
            flip  = 1'($urandom);
            nstop = int'($urandom_range(3, 0));
            eff   = (nstop == 0) ? 1 : nstop;
            mask  = ($urandom_range(3, 0) == 0) ? 3'($urandom) : 3'b000;
            send_frame(data, pen, flip, nstop, mask);
            if (mask[eff-1]) drive_level(1'b1, 16);
            else if ($urandom_range(1, 0) == 1) drive_level(1'b1, int'($urandom_range(16, 1)));
        end
        check_frames("random");
        drive_level(1'b1, 16);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_framing();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
